// File: rtl/ula_sequenciador.sv
// Purpose: debounces the board keys and sequences operand/operation entry for the ULA datapath.
// Latency: a change on the ULA inputs reaches result_reg/flags/valid SETTLE_CYC+1 cycles later.
// Backpressure: none; key pulses are ignored in EXEC, and any pulse aborts the scan mode.
module ula_sequenciador #(
    parameter int DEBOUNCE_CYC = 500000,
    parameter int SETTLE_CYC   = 4,
    parameter int HOLD_CYC     = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] key_n,
    input  logic [9:0] sw,
    input  logic [7:0] ula_result,
    input  logic       ula_cout,
    output logic [3:0] a_reg,
    output logic [3:0] b_reg,
    output logic       cin_reg,
    output logic [2:0] sel,
    output logic [7:0] result_reg,
    output logic       valid,
    output logic       flag_zero,
    output logic       flag_error,
    output logic       flag_cout,
    output logic [2:0] state_out
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam int TM_MAX = (HOLD_CYC > SETTLE_CYC) ? HOLD_CYC : SETTLE_CYC;
    localparam int TM_W   = $clog2(TM_MAX + 1);

    // Debounce counter terminal value; settle counter counts down to zero inclusive
    // so the latch lands SETTLE_CYC+1 cycles after the inputs change.
    localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [TM_W-1:0] SETTLE_LOAD = TM_W'(SETTLE_CYC);
    localparam logic [TM_W-1:0] HOLD_LOAD   = TM_W'(HOLD_CYC - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GET_A     = 3'd1,
        GET_B     = 3'd2,
        GET_OP    = 3'd3,
        EXEC      = 3'd4,
        SHOW      = 3'd5,
        SCAN_SET  = 3'd6,
        SCAN_HOLD = 3'd7
    } state_t;

    // Keys are carried as "pressed" (inverted key_n) so that the all-zero reset
    // value means "released and stable".
    logic [1:0]            sync1;
    logic [1:0]            sync2;
    logic [1:0]            db_state;
    logic [1:0]            k_pulse;
    logic [1:0][DB_W-1:0]  db_cnt;

    state_t          state, state_nx;
    logic [TM_W-1:0] tmr, tmr_nx;
    logic [3:0]      a_nx, b_nx;
    logic            cin_nx, valid_nx, zero_nx, err_nx, cout_nx;
    logic [2:0]      sel_nx;
    logic [7:0]      res_nx;
    logic            k0, k1, any_key;
    logic            unused_sw;

    assign unused_sw = sw[9];
    assign k1        = k_pulse[1];
    assign k0        = k_pulse[0];
    assign any_key   = k0 | k1;
    assign state_out = state;

    // Per-key synchroniser and stability counter; a pulse fires only on a debounced press edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            db_state <= '0;
            k_pulse  <= '0;
            db_cnt   <= '0;
        end else begin
            sync1 <= ~key_n;
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                k_pulse[i] <= 1'b0;
                if (sync2[i] == db_state[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_cnt[i]   <= '0;
                    db_state[i] <= sync2[i];
                    k_pulse[i]  <= sync2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Next-state and next-register computation; every register holds unless a transition says otherwise.
    always_comb begin
        state_nx = state;
        tmr_nx   = tmr;
        a_nx     = a_reg;
        b_nx     = b_reg;
        cin_nx   = cin_reg;
        sel_nx   = sel;
        res_nx   = result_reg;
        valid_nx = valid;
        zero_nx  = flag_zero;
        err_nx   = flag_error;
        cout_nx  = flag_cout;
        case (state)
            IDLE: begin
                if (k1) begin
                    state_nx = SCAN_SET;
                    sel_nx   = 3'd0;
                    tmr_nx   = SETTLE_LOAD;
                end else if (k0) begin
                    state_nx = GET_A;
                end
            end
            GET_A: begin
                if (k1) begin
                    state_nx = IDLE;
                end else if (k0) begin
                    a_nx     = sw[3:0];
                    cin_nx   = sw[8];
                    state_nx = GET_B;
                end
            end
            GET_B: begin
                if (k1) begin
                    state_nx = IDLE;
                end else if (k0) begin
                    b_nx     = sw[7:4];
                    state_nx = GET_OP;
                end
            end
            GET_OP: begin
                if (k1) begin
                    state_nx = IDLE;
                end else if (k0) begin
                    if (sw[2:0] == 3'd7) begin
                        err_nx = 1'b1;
                    end else begin
                        sel_nx   = sw[2:0];
                        valid_nx = 1'b0;
                        err_nx   = 1'b0;
                        tmr_nx   = SETTLE_LOAD;
                        state_nx = EXEC;
                    end
                end
            end
            EXEC, SCAN_SET: begin
                if ((state == SCAN_SET) && any_key) begin
                    state_nx = IDLE;
                end else if (tmr == '0) begin
                    res_nx   = ula_result;
                    valid_nx = 1'b1;
                    zero_nx  = (ula_result == 8'd0);
                    cout_nx  = ula_cout & (sel == 3'd0);
                    err_nx   = ((sel == 3'd6) && (b_reg == 4'd0)) ||
                               ((sel == 3'd1) && (a_reg < b_reg));
                    if (state == EXEC) begin
                        state_nx = SHOW;
                    end else begin
                        tmr_nx   = HOLD_LOAD;
                        state_nx = SCAN_HOLD;
                    end
                end else begin
                    tmr_nx = tmr - 1'b1;
                end
            end
            SHOW: begin
                if (k1) begin
                    state_nx = IDLE;
                end else if (k0) begin
                    state_nx = GET_A;
                end
            end
            SCAN_HOLD: begin
                if (any_key) begin
                    state_nx = IDLE;
                end else if (tmr == '0) begin
                    sel_nx   = (sel == 3'd6) ? 3'd0 : sel + 3'd1;
                    tmr_nx   = SETTLE_LOAD;
                    state_nx = SCAN_SET;
                end else begin
                    tmr_nx = tmr - 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State, timer and all driven/latched outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tmr        <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            cin_reg    <= 1'b0;
            sel        <= '0;
            result_reg <= '0;
            valid      <= 1'b0;
            flag_zero  <= 1'b0;
            flag_error <= 1'b0;
            flag_cout  <= 1'b0;
        end else begin
            state      <= state_nx;
            tmr        <= tmr_nx;
            a_reg      <= a_nx;
            b_reg      <= b_nx;
            cin_reg    <= cin_nx;
            sel        <= sel_nx;
            result_reg <= res_nx;
            valid      <= valid_nx;
            flag_zero  <= zero_nx;
            flag_error <= err_nx;
            flag_cout  <= cout_nx;
        end
    end

endmodule

// File: tb/tb_ula_sequenciador.sv
// Purpose: directed self-checking bench for ula_sequenciador with a behavioural ULA on its inputs.
// Latency: expects latch SETTLE_CYC+1 cycles after EXEC entry and a 25-cycle scan step.
// Backpressure: not applicable; keys are driven as slow human-like presses.
module tb_ula_sequenciador;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] key_n;
    logic [9:0] sw;
    logic [7:0] ula_result;
    logic       ula_cout;
    logic [3:0] a_reg, b_reg;
    logic       cin_reg;
    logic [2:0] sel;
    logic [7:0] result_reg;
    logic       valid, flag_zero, flag_error, flag_cout;
    logic [2:0] state_out;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_scan [7];
    logic [7:0] held_res;

    ula_sequenciador #(
        .DEBOUNCE_CYC(8),
        .SETTLE_CYC  (4),
        .HOLD_CYC    (20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_n      (key_n),
        .sw         (sw),
        .ula_result (ula_result),
        .ula_cout   (ula_cout),
        .a_reg      (a_reg),
        .b_reg      (b_reg),
        .cin_reg    (cin_reg),
        .sel        (sel),
        .result_reg (result_reg),
        .valid      (valid),
        .flag_zero  (flag_zero),
        .flag_error (flag_error),
        .flag_cout  (flag_cout),
        .state_out  (state_out)
    );

    always #5 clk = ~clk;

    // Behavioural ULA: {cout, result}
    function automatic logic [8:0] ula_fn(input logic [3:0] a, input logic [3:0] b,
                                          input logic c, input logic [2:0] s);
        logic [4:0] t;
        logic [7:0] r;
        logic [3:0] d;
        t = 5'd0;
        r = 8'd0;
        d = 4'd0;
        case (s)
            3'd0: begin
                t = {1'b0, a} + {1'b0, b} + {4'd0, c};
                return {t[4], 4'd0, t[3:0]};
            end
            3'd1: begin
                d = a - b;
                return {5'd0, d};
            end
            3'd2: return {5'd0, a & b};
            3'd3: return {5'd0, a | b};
            3'd4: begin
                r = {4'd0, a} * {4'd0, b};
                return {1'b0, r};
            end
            3'd5: return {5'd0, a ^ b};
            3'd6: begin
                if (b != 4'd0) d = a / b;
                return {5'd0, d};
            end
            default: return 9'd0;
        endcase
    endfunction

    always_comb begin
        {ula_cout, ula_result} = ula_fn(a_reg, b_reg, cin_reg, sel);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input string tag);
        int n;
        n = 0;
        while (state_out !== s && n < 60) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(state_out), 32'(s));
    endtask

    task automatic press(input int k);
        key_n[k] = 1'b0;
        repeat (20) @(negedge clk);
        key_n[k] = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic enter_operands(input logic [3:0] a, input logic [3:0] b, input logic c);
        press(0);
        sw = {1'b0, c, b, a};
        press(0);
        press(0);
    endtask

    task automatic exec_op(input logic [2:0] op);
        sw = {7'd0, op};
        key_n[0] = 1'b0;
        wait_state(3'd4, "exec_entry");
        repeat (5) @(negedge clk);
        key_n[0] = 1'b1;
        repeat (20) @(negedge clk);
        check("show_state", 32'(state_out), 32'd5);
    endtask

    initial begin
        exp_scan[0] = 8'h06; exp_scan[1] = 8'h0E; exp_scan[2] = 8'h08; exp_scan[3] = 8'h0E;
        exp_scan[4] = 8'h78; exp_scan[5] = 8'h06; exp_scan[6] = 8'h00;
        rst   = 1'b1;
        key_n = 2'b11;
        sw    = 10'd0;
        repeat (3) @(negedge clk);
        check("rst_state", 32'(state_out), 32'd0);
        check("rst_result", 32'(result_reg), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_sel", 32'(sel), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // 1: basic sum 5+3+1
        press(0);
        check("idle_to_get_a", 32'(state_out), 32'd1);
        sw = {1'b0, 1'b1, 4'd3, 4'd5};
        press(0);
        check("get_b_state", 32'(state_out), 32'd2);
        check("a_latched", 32'(a_reg), 32'd5);
        check("cin_latched", 32'(cin_reg), 32'd1);
        press(0);
        check("get_op_state", 32'(state_out), 32'd3);
        check("b_latched", 32'(b_reg), 32'd3);
        sw = 10'd0;
        key_n[0] = 1'b0;
        wait_state(3'd4, "t1_exec_entry");
        repeat (4) @(negedge clk);
        check("t1_still_exec", 32'(state_out), 32'd4);
        check("t1_valid_early", 32'(valid), 32'd0);
        @(negedge clk);
        check("t1_show", 32'(state_out), 32'd5);
        check("t1_valid", 32'(valid), 32'd1);
        check("t1_result", 32'(result_reg), 32'd9);
        check("t1_zero", 32'(flag_zero), 32'd0);
        check("t1_cout", 32'(flag_cout), 32'd0);
        check("t1_error", 32'(flag_error), 32'd0);
        key_n[0] = 1'b1;
        repeat (20) @(negedge clk);

        // 2: error conditions and other ops
        enter_operands(4'd7, 4'd0, 1'b0); exec_op(3'd6);
        check("div0_error", 32'(flag_error), 32'd1);
        check("div0_zero", 32'(flag_zero), 32'd1);
        enter_operands(4'd2, 4'd9, 1'b0); exec_op(3'd1);
        check("negsub_error", 32'(flag_error), 32'd1);
        check("negsub_result", 32'(result_reg), 32'd9);
        enter_operands(4'd9, 4'd2, 1'b0); exec_op(3'd1);
        check("sub_result", 32'(result_reg), 32'd7);
        check("sub_error", 32'(flag_error), 32'd0);
        enter_operands(4'd15, 4'd1, 1'b1); exec_op(3'd0);
        check("carry_result", 32'(result_reg), 32'd1);
        check("carry_cout", 32'(flag_cout), 32'd1);
        enter_operands(4'd15, 4'd15, 1'b0); exec_op(3'd4);
        check("mult_result", 32'(result_reg), 32'hE1);
        check("mult_cout", 32'(flag_cout), 32'd0);

        // 3: invalid op code rejected
        enter_operands(4'hA, 4'hC, 1'b0);
        sw = 10'd7;
        press(0);
        check("op7_state", 32'(state_out), 32'd3);
        check("op7_error", 32'(flag_error), 32'd1);
        check("op7_sel", 32'(sel), 32'd4);
        exec_op(3'd2);
        check("and_result", 32'(result_reg), 32'd8);
        check("and_error", 32'(flag_error), 32'd0);
        check("and_sel", 32'(sel), 32'd2);

        // 4: debounce behaviour and key priority
        key_n[0] = 1'b0;
        repeat (5) @(negedge clk);
        key_n[0] = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_ignored", 32'(state_out), 32'd5);
        sw = {2'b00, 4'hC, 4'hA};
        key_n[0] = 1'b0;
        repeat (30) @(negedge clk);
        key_n[0] = 1'b1;
        repeat (20) @(negedge clk);
        check("long_press_once", 32'(state_out), 32'd1);
        press(0);
        check("to_get_b", 32'(state_out), 32'd2);
        key_n = 2'b00;
        repeat (20) @(negedge clk);
        key_n = 2'b11;
        repeat (20) @(negedge clk);
        check("k1_priority", 32'(state_out), 32'd0);

        // 5: scan mode with A=0xA, B=0xC, cin=0
        key_n[1] = 1'b0;
        wait_state(3'd6, "scan_entry");
        key_n[1] = 1'b1;
        check("scan_sel0", 32'(sel), 32'd0);
        for (int i = 1; i <= 7; i++) begin
            repeat (24) @(negedge clk);
            check("scan_hold", 32'(state_out), 32'd7);
            check("scan_result", 32'(result_reg), 32'(exp_scan[i-1]));
            @(negedge clk);
            check("scan_set", 32'(state_out), 32'd6);
            check("scan_sel", 32'(sel), 32'(i % 7));
        end
        repeat (10) @(negedge clk);
        check("scan_hold_again", 32'(state_out), 32'd7);
        held_res = result_reg;
        key_n[0] = 1'b0;
        wait_state(3'd0, "scan_abort");
        check("abort_result_held", 32'(result_reg), 32'h06);
        check("abort_valid_held", 32'(valid), 32'd1);
        key_n[0] = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_result_stable", 32'(result_reg), 32'(held_res));

        // 6: asynchronous reset mid-EXEC
        enter_operands(4'd3, 4'd4, 1'b0);
        sw = 10'd0;
        key_n[0] = 1'b0;
        wait_state(3'd4, "t6_exec_entry");
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_state", 32'(state_out), 32'd0);
        check("arst_a", 32'(a_reg), 32'd0);
        check("arst_b", 32'(b_reg), 32'd0);
        check("arst_result", 32'(result_reg), 32'd0);
        check("arst_valid", 32'(valid), 32'd0);
        key_n = 2'b11;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("post_rst_idle", 32'(state_out), 32'd0);
        press(0);
        check("post_rst_alive", 32'(state_out), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
